// File: rtl/note_sequencer_pkg.sv
// note_sequencer_pkg
// Shared definitions for the note sequencer: FSM state encoding, song-entry
// field layout, default articulation gap and the note-to-half-period table.
// Half-periods assume a 1 MHz tone-generator clock: note 1 is C4 and each
// code above it is one equal-tempered semitone higher. Code 0 is a rest.
package note_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Song entry: [15] end flag, [14:10] note code, [9:0] duration in ms
  localparam int ENTRY_W  = 16;
  localparam int END_BIT  = 15;
  localparam int NOTE_LSB = 10;
  localparam int NOTE_W   = 5;
  localparam int DUR_LSB  = 0;
  localparam int DUR_W    = 10;

  localparam int TPM_W    = 16;
  localparam int PERIOD_W = 16;
  localparam int LED_W    = 8;

  localparam int GAP_MS_DEFAULT = 10;

  localparam logic [PERIOD_W-1:0] NOTE_HALF_PERIOD [32] = '{
    16'd0,
    16'd1911, 16'd1804, 16'd1703, 16'd1607, 16'd1517, 16'd1432,
    16'd1351, 16'd1276, 16'd1204, 16'd1136, 16'd1073, 16'd1012,
    16'd956,  16'd902,  16'd851,  16'd804,  16'd758,  16'd716,
    16'd676,  16'd638,  16'd602,  16'd568,  16'd536,  16'd506,
    16'd478,  16'd451,  16'd426,  16'd402,  16'd379,  16'd358,
    16'd338
  };

  function automatic logic [PERIOD_W-1:0] note_period(input logic [NOTE_W-1:0] note);
    return NOTE_HALF_PERIOD[note];
  endfunction

  function automatic logic [LED_W-1:0] note_led(input logic [2:0] sel);
    return LED_W'(1) << sel;
  endfunction

endpackage

// File: rtl/note_sequencer_song_rom.sv
// song_rom
// Song table, STEPS entries of ENTRY_W bits. Synchronous write port used to
// load a song while the sequencer is idle; synchronous read with a registered
// output, so data for an address presented in one cycle appears the next.
// Ports:
//   i_clk, i_rst         clock, async active-high reset (clears read register)
//   i_we/i_waddr/i_wdata write port
//   i_raddr              read address
//   o_rdata              registered read data
module song_rom
  import note_sequencer_pkg::*;
#(
  parameter int STEPS = 32,
  parameter int IDX_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]   i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [STEPS];
  logic [ENTRY_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rdata <= '0;
    else       r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
// Plays a song table as a sequence of notes for a tone generator. Each entry
// is played for its duration in milliseconds followed by a silent gap of
// GAP_MS milliseconds. Milliseconds are timed with a prescaler running at
// i_ticks_per_milli clk cycles (0 treated as 1).
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_ticks_per_milli       clk cycles per millisecond
//   i_start, i_stop         start playback when idle / abort (stop wins)
//   i_loop_en               restart at step 0 at end of song
//   i_rom_we/waddr/wdata    song table write port
//   o_busy, o_done          not idle / one-cycle completion pulse
//   o_step_idx              current song entry
//   o_tone_period, o_tone_en, o_led   tone generator and indicator outputs
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter  int STEPS  = 32,
  parameter  int GAP_MS = GAP_MS_DEFAULT,
  localparam int IDX_W  = $clog2(STEPS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [TPM_W-1:0]    i_ticks_per_milli,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_loop_en,
  input  logic                i_rom_we,
  input  logic [IDX_W-1:0]    i_rom_waddr,
  input  logic [ENTRY_W-1:0]  i_rom_wdata,
  output logic                o_busy,
  output logic                o_done,
  output logic [IDX_W-1:0]    o_step_idx,
  output logic [PERIOD_W-1:0] o_tone_period,
  output logic                o_tone_en,
  output logic [LED_W-1:0]    o_led
);

  localparam logic [DUR_W-1:0] GAP_MS_CNT = DUR_W'(GAP_MS);

  state_t              r_state;
  logic [IDX_W-1:0]    r_step_idx;
  logic [DUR_W-1:0]    r_ms_cnt;
  logic [TPM_W-1:0]    r_tick_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_tone_en;
  logic [PERIOD_W-1:0] r_tone_period;
  logic [LED_W-1:0]    r_led;

  logic [ENTRY_W-1:0]  w_entry;
  logic                w_end;
  logic [NOTE_W-1:0]   w_note;
  logic [DUR_W-1:0]    w_dur;
  logic [TPM_W-1:0]    w_tick_reload;
  logic                w_ms_last;
  logic                w_last_step;

  song_rom #(
    .STEPS (STEPS),
    .IDX_W (IDX_W)
  ) u_song_rom (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (i_rom_we),
    .i_waddr (i_rom_waddr),
    .i_wdata (i_rom_wdata),
    .i_raddr (r_step_idx),
    .o_rdata (w_entry)
  );

  assign w_end  = w_entry[END_BIT];
  assign w_note = w_entry[NOTE_LSB +: NOTE_W];
  assign w_dur  = w_entry[DUR_LSB +: DUR_W];

  // Prescaler reload: one millisecond is tick counts reload..0
  assign w_tick_reload = (i_ticks_per_milli == '0) ? '0 : i_ticks_per_milli - TPM_W'(1);

  // Final cycle of a PLAY/GAP interval; a zero-length interval still takes one cycle
  assign w_ms_last = (r_ms_cnt == '0) || ((r_tick_cnt == '0) && (r_ms_cnt == DUR_W'(1)));

  assign w_last_step = (r_step_idx == IDX_W'(STEPS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_step_idx    <= '0;
      r_ms_cnt      <= '0;
      r_tick_cnt    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_tone_en     <= 1'b0;
      r_tone_period <= '0;
      r_led         <= '0;
    end else if (i_stop) begin
      r_state       <= S_IDLE;
      r_ms_cnt      <= '0;
      r_tick_cnt    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_tone_en     <= 1'b0;
      r_tone_period <= '0;
      r_led         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state    <= S_FETCH;
            r_step_idx <= '0;
            r_busy     <= 1'b1;
          end
        end

        S_FETCH: r_state <= S_LOAD;

        S_LOAD: begin
          if (w_end) begin
            if (i_loop_en) begin
              r_step_idx <= '0;
              r_state    <= S_FETCH;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_tone_period <= note_period(w_note);
            r_tone_en     <= (w_note != '0);
            r_led         <= (w_note != '0) ? note_led(w_note[2:0]) : '0;
            r_ms_cnt      <= w_dur;
            r_tick_cnt    <= w_tick_reload;
            r_state       <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (w_ms_last) begin
            r_tone_en     <= 1'b0;
            r_tone_period <= '0;
            r_led         <= '0;
            r_ms_cnt      <= GAP_MS_CNT;
            r_tick_cnt    <= w_tick_reload;
            r_state       <= S_GAP;
          end else if (r_tick_cnt == '0) begin
            r_ms_cnt   <= r_ms_cnt - DUR_W'(1);
            r_tick_cnt <= w_tick_reload;
          end else begin
            r_tick_cnt <= r_tick_cnt - TPM_W'(1);
          end
        end

        S_GAP: begin
          if (w_ms_last) begin
            // Running off the end of the table behaves like an end flag
            if (!w_last_step) begin
              r_step_idx <= r_step_idx + IDX_W'(1);
              r_state    <= S_FETCH;
            end else if (i_loop_en) begin
              r_step_idx <= '0;
              r_state    <= S_FETCH;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (r_tick_cnt == '0) begin
            r_ms_cnt   <= r_ms_cnt - DUR_W'(1);
            r_tick_cnt <= w_tick_reload;
          end else begin
            r_tick_cnt <= r_tick_cnt - TPM_W'(1);
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_step_idx    = r_step_idx;
  assign o_tone_period = r_tone_period;
  assign o_tone_en     = r_tone_en;
  assign o_led         = r_led;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer. A reference model expands a song into the
// expected per-cycle output trace (segment lengths from the entry durations),
// which is compared against the DUT one cycle at a time.
module tb_note_sequencer;

  localparam int STEPS  = 32;
  localparam int GAP_MS = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tpm = 16'd1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        rom_we = 1'b0;
  logic [4:0]  rom_waddr = '0;
  logic [15:0] rom_wdata = '0;
  logic        busy, done, tone_en;
  logic [4:0]  step_idx;
  logic [15:0] tone_period;
  logic [7:0]  led;

  note_sequencer #(.STEPS(STEPS), .GAP_MS(GAP_MS)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_ticks_per_milli (tpm),
    .i_start           (start),
    .i_stop            (stop),
    .i_loop_en         (loop_en),
    .i_rom_we          (rom_we),
    .i_rom_waddr       (rom_waddr),
    .i_rom_wdata       (rom_wdata),
    .o_busy            (busy),
    .o_done            (done),
    .o_step_idx        (step_idx),
    .o_tone_period     (tone_period),
    .o_tone_en         (tone_en),
    .o_led             (led)
  );

  always #5 clk = ~clk;

  // Equal-tempered half-periods at 1 MHz, C4 upward; code 0 is a rest
  localparam logic [15:0] HALF [32] = '{
    16'd0,
    16'd1911, 16'd1804, 16'd1703, 16'd1607, 16'd1517, 16'd1432,
    16'd1351, 16'd1276, 16'd1204, 16'd1136, 16'd1073, 16'd1012,
    16'd956,  16'd902,  16'd851,  16'd804,  16'd758,  16'd716,
    16'd676,  16'd638,  16'd602,  16'd568,  16'd536,  16'd506,
    16'd478,  16'd451,  16'd426,  16'd402,  16'd379,  16'd358,
    16'd338
  };

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] song [STEPS];
  logic [31:0] exp_q [$];
  int          drop_idx;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (busy,done,en,step,period,led)", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input bit b, input bit d, input bit e, input int step,
                                     input logic [15:0] per, input logic [7:0] l);
    return {b, d, e, 5'(step), per, l};
  endfunction

  function automatic logic [31:0] obs();
    return {busy, done, tone_en, step_idx, tone_period, led};
  endfunction

  // Expand the song into the expected output after each clk edge, edge 0
  // being the one that samples start. 'loops' end-of-song events restart.
  task automatic build_model(input int t_in, input int loops);
    int t, step, passes, n, g;
    bit fin, ended;
    logic [15:0] e;
    logic [4:0]  note;
    logic [7:0]  l;
    t = (t_in == 0) ? 1 : t_in;
    step = 0; passes = 0; fin = 0;
    exp_q.delete();
    drop_idx = -1;
    exp_q.push_back(pk(1, 0, 0, 0, 16'd0, 8'd0));
    exp_q.push_back(pk(1, 0, 0, 0, 16'd0, 8'd0));
    while (!fin) begin
      e = song[step];
      ended = 0;
      if (e[15]) begin
        ended = 1;
      end else begin
        note = e[14:10];
        l = 8'd0;
        if (note != 0) l[note[2:0]] = 1'b1;
        n = int'(e[9:0]) * t;
        if (n == 0) n = 1;
        for (int k = 0; k < n; k++) exp_q.push_back(pk(1, 0, note != 0, step, HALF[note], l));
        g = GAP_MS * t;
        if (g == 0) g = 1;
        for (int k = 0; k < g; k++) exp_q.push_back(pk(1, 0, 0, step, 16'd0, 8'd0));
        if (step == STEPS - 1) ended = 1;
        else begin
          step++;
          exp_q.push_back(pk(1, 0, 0, step, 16'd0, 8'd0));
          exp_q.push_back(pk(1, 0, 0, step, 16'd0, 8'd0));
        end
      end
      if (ended) begin
        if (passes < loops) begin
          passes++;
          step = 0;
          drop_idx = exp_q.size();
          exp_q.push_back(pk(1, 0, 0, 0, 16'd0, 8'd0));
          exp_q.push_back(pk(1, 0, 0, 0, 16'd0, 8'd0));
        end else begin
          exp_q.push_back(pk(1, 1, 0, step, 16'd0, 8'd0));
          exp_q.push_back(pk(0, 0, 0, step, 16'd0, 8'd0));
          fin = 1;
        end
      end
    end
  endtask

  task automatic load_song();
    for (int a = 0; a < STEPS; a++) begin
      @(negedge clk);
      rom_we = 1'b1; rom_waddr = 5'(a); rom_wdata = song[a];
    end
    @(negedge clk);
    rom_we = 1'b0;
  endtask

  // Play the loaded song and compare every cycle; optional stop after obs stop_at
  task automatic run_song(input string name, input int t_in, input int loops,
                          input int stop_at, input int hold);
    build_model(t_in, loops);
    tpm = 16'(t_in);
    @(negedge clk);
    start = 1'b1;
    loop_en = (0 <= drop_idx);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i + 1 >= hold) start = 1'b0;
      loop_en = (i + 1 <= drop_idx);
      check_vec($sformatf("%s[%0d]", name, i), obs(), exp_q[i]);
      if (i == stop_at) begin
        stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stop = 1'b0;
        check_vec($sformatf("%s_stop", name), obs(), pk(0, 0, 0, int'(exp_q[i][28:24]), 16'd0, 8'd0));
        break;
      end
    end
    start = 1'b0;
    loop_en = 1'b0;
  endtask

  task automatic clear_song();
    for (int a = 0; a < STEPS; a++) song[a] = 16'h8000;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_vec("reset_held", obs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_vec("reset_released", obs(), 32'd0);

    // note 10 for 3 ms at 4 ticks/ms, then end
    clear_song();
    song[0] = {1'b0, 5'd10, 10'd3};
    load_song();
    run_song("basic", 4, 0, -1, 1);

    // rest of 5 ms, then a short note
    clear_song();
    song[0] = {1'b0, 5'd0, 10'd5};
    song[1] = {1'b0, 5'd1, 10'd1};
    load_song();
    run_song("rest", 2, 0, -1, 1);

    // looping two-note song, start held into FETCH
    clear_song();
    song[0] = {1'b0, 5'd3, 10'd2};
    song[1] = {1'b0, 5'd17, 10'd1};
    load_song();
    run_song("loop", 1, 3, -1, 2);

    // stop five cycles into a note, then replay from step 0
    clear_song();
    song[0] = {1'b0, 5'd7, 10'd5};
    load_song();
    run_song("stop", 4, 0, 6, 1);
    run_song("replay", 4, 0, -1, 1);

    // ticks_per_milli of 0, zero-duration entry
    clear_song();
    song[0] = {1'b0, 5'd12, 10'd2};
    song[1] = {1'b0, 5'd31, 10'd0};
    load_song();
    run_song("tpm0", 0, 0, -1, 1);

    // full table without end flag: wraps once via loop, then finishes
    for (int a = 0; a < STEPS; a++) song[a] = {1'b0, 5'($urandom_range(0, 31)), 10'($urandom_range(0, 1))};
    load_song();
    run_song("wrap", 1, 1, -1, 1);

    // asynchronous reset mid-note
    clear_song();
    song[0] = {1'b0, 5'd5, 10'd20};
    load_song();
    tpm = 16'd4;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_vec("pre_rst", obs(), pk(1, 0, 1, 0, HALF[5], 8'h20));
    #2 rst = 1'b1;
    #1 check_vec("async_rst", obs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_vec($sformatf("start_stop[%0d]", k), obs(), 32'd0);
    end
    start = 1'b0;
    stop = 1'b0;

    // random songs
    for (int s = 0; s < 15; s++) begin
      int len;
      for (int a = 0; a < STEPS; a++) song[a] = 16'($urandom());
      len = $urandom_range(1, 4);
      for (int a = 0; a < len; a++) song[a] = {1'b0, 5'($urandom_range(0, 31)), 10'($urandom_range(0, 4))};
      song[len] = 16'h8000 | 16'($urandom_range(0, 16'h7fff));
      load_song();
      run_song($sformatf("rnd%0d", s), $urandom_range(0, 3), $urandom_range(0, 2), -1, $urandom_range(1, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter STEPS, default 32: song table depth in entries; step_idx width is clog2(STEPS).
REQ-002 Parameter GAP_MS, default 10: silent articulation gap after every note, in milliseconds.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 ticks_per_milli  in  16  clk cycles per millisecond; value 0 SHALL be treated as 1.
REQ-006 start  in  1  level sampled each clk; begins playback at step 0 when idle.
REQ-007 stop  in  1  abort playback; priority over start.
REQ-008 loop_en  in  1  on end-of-song: 1 restarts at step 0, 0 finishes.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse on normal song completion.
REQ-011 step_idx  out  5  index of current song entry.
REQ-012 tone_period  out  16  half-period, in clk cycles, for the tone generator; 0 = silence.
REQ-013 tone_en  out  1  speaker enable for the tone generator.
REQ-014 led  out  8  one-hot of note[2:0] while tone_en=1, else 8'h00.

Function
REQ-015 Song entry SHALL be 16 bits: [15] end flag, [14:10] note code (0 = rest), [9:0] duration in ms.
REQ-016 FSM states SHALL be IDLE, FETCH, LOAD, PLAY, GAP, DONE.
REQ-017 IDLE: start=1 and stop=0 -> FETCH, step_idx cleared to 0; start while busy SHALL be ignored.
REQ-018 FETCH: present step_idx to the song ROM; -> LOAD next cycle (1-cycle registered ROM read).
REQ-019 LOAD, end flag=1: loop_en=1 -> step_idx=0, FETCH; loop_en=0 -> DONE.
REQ-020 LOAD, end flag=0: latch tone_period=period(note), tone_en=(note!=0), ms counter=duration -> PLAY.
REQ-021 tone_en SHALL rise on the second clk edge after the edge that samples start (first note non-rest).
REQ-022 Millisecond prescaler SHALL restart on entry to PLAY and to GAP so the first ms is full length.
REQ-023 PLAY SHALL last exactly duration*ticks_per_milli cycles; duration 0 -> GAP after one cycle.
REQ-024 PLAY->GAP: tone_en=0 and tone_period=0 on the same edge.
REQ-025 GAP SHALL last exactly GAP_MS*ticks_per_milli cycles, then step_idx+1 -> FETCH.
REQ-026 step_idx at STEPS-1 leaving GAP SHALL be treated as end flag (REQ-019 rules), never silent wrap.
REQ-027 DONE: done=1 for one cycle -> IDLE.
REQ-028 stop=1 in any state -> IDLE next edge, tone_en=0, tone_period=0, no done pulse.
REQ-029 ticks_per_milli changes SHALL take effect at the next ms boundary only.

Reset
REQ-030 rst SHALL force IDLE, busy=0, done=0, step_idx=0, tone_period=0, tone_en=0, led=0, counters=0 immediately.
REQ-031 rst asserted mid-note SHALL silence tone_en without waiting for a clock edge.

Structure
REQ-032 Shared package SHALL hold the state enum, entry field widths/offsets, GAP_MS default and the note-to-half-period table (32 entries).
REQ-033 One sub-module song_rom (STEPS x 16, synchronous read, registered output) SHALL be instantiated.

Verification
REQ-034 ticks_per_milli=4, entry0={0,note 10,dur 3}, entry1 end: start -> tone_en high exactly 12 cycles, low 40 cycles (GAP), then done pulse once, busy=0.
REQ-035 Rest entry note 0 dur 5, tpm=2: tone_en stays 0, tone_period=0, PLAY lasts 10 cycles, step_idx advances to 1.
REQ-036 loop_en=1, 2-note song, tpm=1: step_idx sequence 0,1,0,1,...; done never pulses until loop_en=0.
REQ-037 stop asserted 5 cycles into a note: tone_en=0 and busy=0 on next edge; done stays 0; start then replays from step 0.
REQ-038 rst asserted asynchronously mid-PLAY: outputs zero before next clk edge; start and stop high together from IDLE -> remains IDLE.
REQ-039 ticks_per_milli=0, dur 2: PLAY lasts 2 cycles (treated as 1); duration 0 entry -> PLAY 1 cycle then GAP.
